hamming_encoder_7_4: RTL and testbench
======================================

Name: hamming_encoder_7_4

Overview:
Registered Hamming(7,4) single-error-correcting encoder. Takes a 4-bit nibble and produces a 7-bit codeword with three even-parity bits in standard positions 1, 2 and 4. Sits on the transmit side of the UART link, ahead of the serializer; the matching decoder is on the receive side. One codeword per enabled clock; no back-pressure.

Parameters:
None. Widths are fixed at 4 data bits and 7 code bits.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
ena  input  1  encode enable; when high, data_in is sampled this cycle
data_in  input  4  data nibble d[3:0]
code_out  output  7  registered Hamming codeword
valid_out  output  1  high for one cycle per encoded nibble; qualifies code_out

Behaviour:
- Reset (rst_n low, asynchronous): code_out=7'h00, valid_out=0 immediately, regardless of clk. Release is synchronous to clk; first sample occurs on the first rising edge after deassertion.
- Parity equations (even parity, d = data_in):
  - p1 = d0^d1^d3
  - p2 = d0^d2^d3
  - p3 = d1^d2^d3
- Codeword layout uses position k = code_out bit k-1:
  - code_out[0]=p1, [1]=p2, [2]=d0, [3]=p3, [4]=d1, [5]=d2, [6]=d3.
  - So code_out = {d3,d2,d1,p3,d0,p2,p1}.
- Rising clk with ena=1: code_out <= encode(data_in); valid_out <= 1.
- Rising clk with ena=0: code_out holds its previous value; valid_out <= 0.
- Latency: exactly 1 clock from the sampling edge. Back-to-back ena gives one new codeword per cycle with valid_out held high.
- No combinational path from inputs to outputs; both outputs come straight from flops.
- Every valid codeword has syndrome 0: XOR of the positions of all set bits = 0.
- Reset asserted mid-stream: outputs clear at once. The in-flight nibble is discarded and not replayed.
- X/Z on data_in while ena=0 must not propagate to code_out.

Optional Feature:
- Macro: HAMMING_ENC_INPUT_REG_EN.
- Defined:
  - Adds an input stage that registers data_in and ena (reset to 0) before encoding.
  - Total latency is 2 clocks; valid_out follows ena by 2 cycles.
  - Throughput is unchanged at one codeword per cycle.
  - code_out still holds when the delayed enable is 0.
- Undefined: single-stage, 1-cycle latency as described in Behaviour.

Test Plan:
- Reset: rst_n=0 mid-cycle with code_out nonzero -> code_out=7'h00 and valid_out=0 before the next edge; they stay 0 while rst_n=0.
- Known vectors, ena=1, one per cycle, each checked 1 cycle later with valid_out=1:
  - data_in=4'h0 -> 7'h00
  - 4'h1 -> 7'h07
  - 4'h8 -> 7'h4B
  - 4'hB -> 7'h55
  - 4'hF -> 7'h7F
- Exhaustive: all 16 nibbles streamed back-to-back ->
  - each code_out matches the equations
  - the syndrome of each code_out is 0
  - d bits extracted from [6,5,4,2] equal the input
  - valid_out stays high throughout
- Enable gating: encode 4'hB, then ena=0 for 3 cycles with data_in=4'h1 -> code_out stays 7'h55; valid_out=0 on all 3 cycles.
- Reset mid-stream: assert rst_n=0 while ena=1 and data_in=4'hF -> outputs 0 at once. After release with ena=1 and data_in=4'h8 -> 7'h4B one cycle later.
- With HAMMING_ENC_INPUT_REG_EN defined: ena pulse with data_in=4'hB -> valid_out=1 and code_out=7'h55 exactly 2 cycles later, and 0/unchanged on the cycle before.

Source files
------------

// File: rtl/hamming_encoder_7_4.sv
// Registered Hamming(7,4) encoder: codeword {d3,d2,d1,p3,d0,p2,p1}, even parity.
// Define HAMMING_ENC_INPUT_REG_EN to add an input register stage (2-cycle latency).
module hamming_encoder_7_4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] data_in,
    output logic [6:0] code_out,
    output logic       valid_out
);

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CODE_W = 7;

    logic              ena_s;
    logic [DATA_W-1:0] data_s;
    logic [CODE_W-1:0] code_next;
    logic              p1;
    logic              p2;
    logic              p3;

`ifdef HAMMING_ENC_INPUT_REG_EN
    logic              ena_q;
    logic [DATA_W-1:0] data_q;

    // Input stage; data only captured when enabled so idle-cycle X never enters the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ena_q <= ena;
            if (ena) begin
                data_q <= data_in;
            end
        end
    end

    assign ena_s  = ena_q;
    assign data_s = data_q;
`else
    assign ena_s  = ena;
    assign data_s = data_in;
`endif

    // Parity and codeword assembly
    always_comb begin
        p1        = 1'b0;
        p2        = 1'b0;
        p3        = 1'b0;
        code_next = '0;
        p1        = data_s[0] ^ data_s[1] ^ data_s[3];
        p2        = data_s[0] ^ data_s[2] ^ data_s[3];
        p3        = data_s[1] ^ data_s[2] ^ data_s[3];
        code_next = {data_s[3], data_s[2], data_s[1], p3, data_s[0], p2, p1};
    end

    // Output register; code holds while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= ena_s;
            if (ena_s) begin
                code_out <= code_next;
            end
        end
    end

endmodule

// File: tb/tb_hamming_encoder_7_4.sv
// Scoreboard bench for hamming_encoder_7_4: driver queues expected codewords,
// a negedge monitor pops and compares on valid_out, and checks hold/latency.
module tb_hamming_encoder_7_4;

`ifdef HAMMING_ENC_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] data_in;
    logic [6:0] code_out;
    logic       valid_out;

    int checks = 0;
    int errors = 0;

    logic [6:0] exp_q[$];
    logic [LAT-1:0] ena_pipe;
    logic [6:0] held;

    hamming_encoder_7_4 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .data_in  (data_in),
        .code_out (code_out),
        .valid_out(valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Positional construction: data fills non-power-of-two positions 3,5,6,7;
    // parity at position 2^i covers every data position with bit i set.
    function automatic logic [6:0] ref_encode(input logic [3:0] d);
        logic [7:0] w;
        int k;
        logic par;
        w = '0;
        k = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos] = d[k];
                k++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            par = 1'b0;
            for (int pos = 1; pos <= 7; pos++) begin
                if (((pos & (pos - 1)) != 0) && ((pos & (1 << i)) != 0)) par = par ^ w[pos];
            end
            w[1 << i] = par;
        end
        return w[7:1];
    endfunction

    function automatic int syndrome(input logic [6:0] c);
        int s;
        s = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if (c[pos-1]) s = s ^ pos;
        end
        return s;
    endfunction

    // Expected-valid delay line, reset alongside the DUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ena_pipe <= '0;
        else if (LAT == 1) ena_pipe <= LAT'(ena);
        else ena_pipe <= LAT'({ena_pipe, ena});
    end

    // Monitor
    always @(negedge clk) begin
        logic [6:0] exp;
        if (!rst_n) begin
            held = '0;
        end else begin
            checks++;
            if (valid_out !== ena_pipe[LAT-1]) begin
                errors++;
                $display("FAIL valid_latency: got %b want %b at %0t", valid_out, ena_pipe[LAT-1], $time);
            end
            if (valid_out === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: code %h with empty queue at %0t", code_out, $time);
                end else begin
                    exp = exp_q.pop_front();
                    if (code_out !== exp) begin
                        errors++;
                        $display("FAIL codeword: got %h want %h at %0t", code_out, exp, $time);
                    end
                end
                checks++;
                if (syndrome(code_out) != 0) begin
                    errors++;
                    $display("FAIL syndrome: code %h syndrome %0d want 0", code_out, syndrome(code_out));
                end
                checks++;
                if (exp_q.size() > 2 * LAT + 2) begin
                    errors++;
                    $display("FAIL backlog: queue depth %0d want <= %0d", exp_q.size(), 2 * LAT + 2);
                end
                held = code_out;
            end else begin
                checks++;
                if (code_out !== held) begin
                    errors++;
                    $display("FAIL hold: got %h want %h at %0t", code_out, held, $time);
                end
            end
        end
    end

    task automatic drive(input logic e, input logic [3:0] d);
        @(posedge clk);
        #1;
        ena     = e;
        data_in = d;
        if (e) exp_q.push_back(ref_encode(d));
    endtask

    task automatic drive_known(input logic [3:0] d, input logic [6:0] c);
        @(posedge clk);
        #1;
        ena     = 1'b1;
        data_in = d;
        exp_q.push_back(c);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (code_out !== 7'h00 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL %s: code %h valid %b want 00/0", tag, code_out, valid_out);
        end
    endtask

    logic [6:0] known_c[5];
    logic [3:0] known_d[5];
    int seen;

    initial begin
        known_d[0] = 4'h0; known_c[0] = 7'h00;
        known_d[1] = 4'h1; known_c[1] = 7'h07;
        known_d[2] = 4'h8; known_c[2] = 7'h4B;
        known_d[3] = 4'hB; known_c[3] = 7'h55;
        known_d[4] = 4'hF; known_c[4] = 7'h7F;

        rst_n   = 1'b0;
        ena     = 1'b0;
        data_in = 4'h0;
        #1;
        check_zero("reset_initial");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Known vectors
        for (int i = 0; i < 5; i++) drive_known(known_d[i], known_c[i]);
        drive(1'b0, 4'h0);

        // Exhaustive back-to-back, with data extraction checked against the model
        for (int n = 0; n < 16; n++) begin
            logic [6:0] c;
            c = ref_encode(4'(n));
            checks++;
            if ({c[6], c[5], c[4], c[2]} !== 4'(n)) begin
                errors++;
                $display("FAIL extract: nibble %h gave %h", n, {c[6], c[5], c[4], c[2]});
            end
            drive(1'b1, 4'(n));
        end

        // Enable gating: B then three idle cycles with data 1 (code must stay 55)
        drive(1'b1, 4'hB);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'h1);
        for (int i = 0; i < LAT; i++) drive(1'b0, 4'bxxxx);
        checks++;
        if (code_out !== 7'h55 || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL gating: code %h valid %b want 55/0", code_out, valid_out);
        end

        // Random traffic
        for (int i = 0; i < 80; i++) drive(1'($urandom_range(0, 3) != 0), 4'($urandom));
        drive(1'b1, 4'hD);

        // Reset mid-cycle with code_out nonzero
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1 check_zero("reset_async");
        repeat (2) @(posedge clk);
        #1 check_zero("reset_held");
        rst_n = 1'b1;
        ena   = 1'b0;

        // Reset mid-stream with ena=1, data F: in-flight nibble discarded
        drive(1'b1, 4'hF);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 check_zero("reset_midstream");
        @(posedge clk);
        #1 check_zero("reset_midstream_edge");
        rst_n = 1'b1;
        ena   = 1'b1;
        data_in = 4'h8;
        exp_q.push_back(7'h4B);
        @(posedge clk);
        #1 ena = 1'b0;
        data_in = 4'h0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        checks++;
        if (code_out !== 7'h4B || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: code %h valid %b want 4B/1", code_out, valid_out);
        end

        // Drain: all queued expectations must be consumed within a bounded wait
        seen = 0;
        while (exp_q.size() != 0 && seen < 20) begin
            @(posedge clk);
            seen++;
        end
        repeat (LAT + 1) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d codewords never appeared", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
